// File: rtl/sum_diff_pipe.sv
// sum_diff_pipe: two-stage add/subtract pipeline with valid/ready handshake,
// unsigned or two's complement overflow detection, optional saturation and a
// sticky overflow event counter.
module sum_diff_pipe #(
    parameter int WIDTH  = 6,
    parameter int SIGNED = 0,
    parameter int SAT    = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             OF_D,
    output logic [CNT_W-1:0] of_count,
    input  logic             clr_count
);

    localparam logic [WIDTH-1:0] MAX_U = '1;
    localparam logic [WIDTH-1:0] MAX_S = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_s1_valid;
    logic             r_mode;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_of;
    logic [CNT_W-1:0] r_of_count;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_out_xfer;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_raw;
    logic             w_carry;
    logic             w_sa;
    logic             w_sb;
    logic             w_sr;
    logic             w_of_s;
    logic             w_of;
    logic [WIDTH-1:0] w_sat_val;
    logic [WIDTH-1:0] w_res;

    assign w_s2_adv   = !r_out_valid || out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign w_out_xfer = r_out_valid && out_ready;

    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign OF_D      = r_of;
    assign of_count  = r_of_count;

    // One extra bit captures carry (sum) or borrow (difference) for the unsigned case.
    assign w_ext   = r_mode ? ({1'b0, r_a} - {1'b0, r_b}) : ({1'b0, r_a} + {1'b0, r_b});
    assign w_raw   = w_ext[WIDTH-1:0];
    assign w_carry = w_ext[WIDTH];
    assign w_sa    = r_a[WIDTH-1];
    assign w_sb    = r_b[WIDTH-1];
    assign w_sr    = w_raw[WIDTH-1];
    assign w_of_s  = r_mode ? ((w_sa != w_sb) && (w_sr != w_sa))
                            : ((w_sa == w_sb) && (w_sr != w_sa));
    assign w_of    = (SIGNED != 0) ? w_of_s : w_carry;

    // Clamp value: signed overflow direction always follows the sign of inA.
    always_comb begin
        w_sat_val = w_raw;
        if (SIGNED != 0)
            w_sat_val = w_sa ? MIN_S : MAX_S;
        else
            w_sat_val = r_mode ? '0 : MAX_U;
    end

    assign w_res = ((SAT != 0) && w_of) ? w_sat_val : w_raw;

    // Stage 1: capture operands whenever the stage can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_mode     <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_mode <= mode;
                r_a    <= inA;
                r_b    <= inB;
            end
        end
    end

    // Stage 2: register result and overflow flag; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_of        <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_of     <= w_of;
            end
        end
    end

    // Overflow event counter: counts delivered overflowing results, sticks at max, clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_of_count <= '0;
        else if (clr_count)
            r_of_count <= '0;
        else if (w_out_xfer && r_of && (r_of_count != CNT_MAX))
            r_of_count <= r_of_count + 1'b1;
    end

endmodule

// File: tb/tb_sum_diff_pipe.sv
// Bench for sum_diff_pipe: four WIDTH=6 instances (unsigned/signed x wrap/sat)
// share one stimulus stream; a queue scoreboard holds expected results.
module tb_sum_diff_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       mode;
    logic [5:0] in_a;
    logic [5:0] in_b;
    logic       out_ready;
    logic       clr_count;

    logic       ir    [4];
    logic       ov    [4];
    logic [5:0] res_w [4];
    logic       of_w  [4];
    logic [7:0] cnt_w [4];

    int tests = 0;
    int fails = 0;
    int delivered = 0;

    typedef struct packed {
        logic [3:0]      of;
        logic [3:0][5:0] res;
    } exp_t;

    exp_t q[$];
    int   exp_cnt [4];
    logic prev_stall;
    logic [5:0] prev_res [4];
    logic       prev_of  [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sum_diff_pipe #(.WIDTH(6), .SIGNED(g / 2), .SAT(g % 2), .CNT_W(8)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .mode      (mode),
            .inA       (in_a),
            .inB       (in_b),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .result    (res_w[g]),
            .OF_D      (of_w[g]),
            .of_count  (cnt_w[g]),
            .clr_count (clr_count)
        );
    end

    // Reference: exact integer arithmetic, then range check and clamp/wrap.
    function automatic logic [6:0] model(input logic [5:0] a, input logic [5:0] b,
                                         input logic m, input int sgn, input int sat);
        int ea, eb, ex, lo, hi, r;
        logic [6:0] o;
        ea = int'(a);
        eb = int'(b);
        if (sgn != 0) begin
            if (a[5]) ea = ea - 64;
            if (b[5]) eb = eb - 64;
            lo = -32; hi = 31;
        end else begin
            lo = 0; hi = 63;
        end
        ex = m ? ea - eb : ea + eb;
        r = ex;
        if (sat != 0 && ex > hi) r = hi;
        if (sat != 0 && ex < lo) r = lo;
        o[5:0] = r[5:0];
        o[6]   = (ex > hi) || (ex < lo);
        return o;
    endfunction

    function automatic exp_t build(input logic [5:0] a, input logic [5:0] b, input logic m);
        exp_t e;
        logic [6:0] t;
        for (int k = 0; k < 4; k++) begin
            t = model(a, b, m, k / 2, k % 2);
            e.res[k] = t[5:0];
            e.of[k]  = t[6];
        end
        return e;
    endfunction

    // Scoreboard monitor: sampled on the falling edge, ahead of the next active edge.
    exp_t e_front;
    logic xfer, have_front, exp_ir;
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
            prev_stall = 1'b0;
        end else begin
            xfer = ov[0] && out_ready;
            exp_ir = !(q.size() == 2 && !out_ready);
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (ir[k] !== exp_ir) begin
                    fails++;
                    $display("FAIL in_ready[%0d]: got %b expected %b (occupancy %0d)", k, ir[k], exp_ir, q.size());
                end
                tests++;
                if (cnt_w[k] !== 8'(exp_cnt[k])) begin
                    fails++;
                    $display("FAIL of_count[%0d]: got %0d expected %0d", k, cnt_w[k], exp_cnt[k]);
                end
            end
            if (prev_stall) begin
                for (int k = 0; k < 4; k++) begin
                    tests++;
                    if (ov[k] !== 1'b1 || res_w[k] !== prev_res[k] || of_w[k] !== prev_of[k]) begin
                        fails++;
                        $display("FAIL hold[%0d]: got v=%b r=%0d of=%b expected v=1 r=%0d of=%b",
                                 k, ov[k], res_w[k], of_w[k], prev_res[k], prev_of[k]);
                    end
                end
            end
            have_front = 1'b0;
            if (xfer) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got result %0d with no pending operand set", res_w[0]);
                end else begin
                    e_front = q.pop_front();
                    have_front = 1'b1;
                    delivered++;
                    for (int k = 0; k < 4; k++) begin
                        tests++;
                        if (res_w[k] !== e_front.res[k] || of_w[k] !== e_front.of[k]) begin
                            fails++;
                            $display("FAIL result[%0d]: got %0d of=%b expected %0d of=%b",
                                     k, res_w[k], of_w[k], e_front.res[k], e_front.of[k]);
                        end
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (clr_count)
                    exp_cnt[k] = 0;
                else if (have_front && e_front.of[k] && exp_cnt[k] != 255)
                    exp_cnt[k] = exp_cnt[k] + 1;
            end
            if (in_valid && ir[0])
                q.push_back(build(in_a, in_b, mode));
            prev_stall = ov[0] && !out_ready;
            for (int k = 0; k < 4; k++) begin
                prev_res[k] = res_w[k];
                prev_of[k]  = of_w[k];
            end
        end
    end

    task automatic test_reset();
        #1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (ov[k] !== 1'b0 || res_w[k] !== 6'd0 || of_w[k] !== 1'b0 || cnt_w[k] !== 8'd0 || ir[k] !== 1'b1) begin
                fails++;
                $display("FAIL reset_state[%0d]: got v=%b r=%0d of=%b cnt=%0d rdy=%b expected v=0 r=0 of=0 cnt=0 rdy=1",
                         k, ov[k], res_w[k], of_w[k], cnt_w[k], ir[k]);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_latency();
        mode = 1'b1; in_a = 6'd45; in_b = 6'd8; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (ir[0] !== 1'b1) begin
            fails++;
            $display("FAIL first_accept: got in_ready %b expected 1", ir[0]);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (ov[0] !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: got out_valid %b expected 0", ov[0]);
        end
        @(posedge clk); #1;
        tests++;
        if (ov[0] !== 1'b1 || res_w[0] !== 6'd37 || of_w[0] !== 1'b0) begin
            fails++;
            $display("FAIL latency_result: got v=%b r=%0d of=%b expected v=1 r=37 of=0", ov[0], res_w[0], of_w[0]);
        end
        @(posedge clk); #1;
        tests++;
        if (ov[0] !== 1'b0) begin
            fails++;
            $display("FAIL latency_drain: got out_valid %b expected 0", ov[0]);
        end
    endtask

    task automatic test_vectors();
        logic [5:0] ta [8] = '{6'd3, 6'd31, 6'd32, 6'd63, 6'd0, 6'd32, 6'd31, 6'd10};
        logic [5:0] tb [8] = '{6'd11, 6'd1, 6'd1, 6'd1, 6'd0, 6'd32, 6'd63, 6'd20};
        logic       tm [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int start;
        start = delivered;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i < 8) begin
                in_a = ta[i]; in_b = tb[i]; mode = tm[i];
            end else begin
                in_a = 6'($urandom_range(0, 63));
                in_b = 6'($urandom_range(0, 63));
                mode = 1'($urandom_range(0, 1));
            end
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (delivered - start != 24 || q.size() != 0) begin
            fails++;
            $display("FAIL throughput: got %0d delivered (%0d pending) expected 24 delivered 0 pending",
                     delivered - start, q.size());
        end
    endtask

    task automatic test_back_to_back();
        int start, sent, cyc;
        logic saw_stall;
        start = delivered; sent = 0; cyc = 0; saw_stall = 1'b0;
        in_a = 6'($urandom_range(0, 63)); in_b = 6'($urandom_range(0, 63));
        mode = 1'($urandom_range(0, 1)); in_valid = 1'b1;
        while (sent < 8 && cyc < 200) begin
            out_ready = (cyc % 2 == 0);
            @(negedge clk);
            if (!ir[0]) saw_stall = 1'b1;
            else sent++;
            @(posedge clk); #1;
            cyc++;
            if (sent >= 8) in_valid = 1'b0;
            else if (ir[0] || 1'b1) begin
                if (in_valid && q.size() > 0 && q.size() + delivered - start == sent) begin
                    in_a = 6'($urandom_range(0, 63)); in_b = 6'($urandom_range(0, 63));
                    mode = 1'($urandom_range(0, 1));
                end
            end
        end
        while (q.size() > 0 && cyc < 300) begin
            out_ready = (cyc % 2 == 0);
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        tests++;
        if (delivered - start != 8 || sent != 8) begin
            fails++;
            $display("FAIL b2b_count: got sent=%0d delivered=%0d expected 8/8", sent, delivered - start);
        end
        tests++;
        if (saw_stall !== 1'b1) begin
            fails++;
            $display("FAIL b2b_stall: got in_ready-low seen=%b expected 1", saw_stall);
        end
    endtask

    task automatic test_reset_flight();
        out_ready = 1'b0;
        in_a = 6'd63; in_b = 6'd63; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_a = 6'd5; in_b = 6'd7;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
            fails++;
            $display("FAIL flight_full: got in_ready=%b out_valid=%b expected 0/1", ir[0], ov[0]);
        end
        @(posedge clk); #2 rst_n = 1'b0;
        q.delete();
        #1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (ov[k] !== 1'b0 || cnt_w[k] !== 8'd0 || ir[k] !== 1'b1 || res_w[k] !== 6'd0 || of_w[k] !== 1'b0) begin
                fails++;
                $display("FAIL async_reset[%0d]: got v=%b cnt=%0d rdy=%b r=%0d of=%b expected 0/0/1/0/0",
                         k, ov[k], cnt_w[k], ir[k], res_w[k], of_w[k]);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (ov[0] !== 1'b0) begin
                fails++;
                $display("FAIL stale_output: got out_valid %b result %0d expected out_valid 0", ov[0], res_w[0]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_of_count();
        out_ready = 1'b1;
        in_a = 6'd32; in_b = 6'd32; mode = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (cnt_w[k] !== 8'd255) begin
                fails++;
                $display("FAIL of_count_sat[%0d]: got %0d expected 255", k, cnt_w[k]);
            end
        end
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (ov[0] !== 1'b1 || of_w[0] !== 1'b1) begin
            fails++;
            $display("FAIL clr_setup: got v=%b of=%b expected 1/1", ov[0], of_w[0]);
        end
        clr_count = 1'b1;
        @(posedge clk); #1 clr_count = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (cnt_w[k] !== 8'd0) begin
                fails++;
                $display("FAIL clr_vs_inc[%0d]: got %0d expected 0", k, cnt_w[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b1; clr_count = 1'b0;
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_reset_flight();
        test_of_count();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 ns expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sum_diff_pipe.md
SUM_DIFF_PIPE -- requirements
Module: sum_diff_pipe

Interface
REQ-001: Parameter WIDTH, default 6, operand and result width in bits (legal 2..32).
REQ-002: Parameter SIGNED, default 0; 0 treats operands as unsigned, 1 as two's complement.
REQ-003: Parameter SAT, default 0; 0 wraps the result on overflow, 1 saturates it.
REQ-004: Parameter CNT_W, default 8, width of the overflow event counter.
REQ-005: clk  input  1  single clock; all state updates on its rising edge.
REQ-006: rst_n  input  1  asynchronous active-low reset.
REQ-007: in_valid  input  1  operand set present on inA/inB/mode.
REQ-008: in_ready  output  1  block accepts an operand set this cycle.
REQ-009: mode  input  1  0 = sum (inA+inB), 1 = difference (inA-inB).
REQ-010: inA  input  WIDTH  first operand.
REQ-011: inB  input  WIDTH  second operand.
REQ-012: out_valid  output  1  result/OF_D hold a valid result.
REQ-013: out_ready  input  1  downstream accepts the result this cycle.
REQ-014: result  output  WIDTH  sum or difference.
REQ-015: OF_D  output  1  overflow flag for the result currently presented.
REQ-016: of_count  output  CNT_W  number of accepted results with OF_D=1.
REQ-017: clr_count  input  1  synchronous clear of of_count.

Function
REQ-018: Two-stage pipeline: stage 1 registers inA, inB, mode; stage 2 registers result and OF_D; input-to-output latency is 2 cycles with out_ready held high.
REQ-019: Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-020: Stage 2 advances when !out_valid || out_ready; stage 1 advances when its valid bit is clear or stage 2 advances; in_ready equals the stage-1 advance condition (combinational, no in_valid dependency).
REQ-021: Full throughput: one result per cycle while in_valid and out_ready are held high.
REQ-022: With out_ready low, result, OF_D and out_valid hold stable; the pipe absorbs up to 2 operand sets, then in_ready drops low.
REQ-023: Unsigned overflow: sum overflows on carry out of bit WIDTH-1; difference overflows on borrow (inA < inB).
REQ-024: Signed overflow: sum overflows when the operand signs match and the result sign differs; difference overflows when the operand signs differ and the result sign differs from inA.
REQ-025: SAT=0: result is the low WIDTH bits of the exact arithmetic result.
REQ-026: SAT=1: unsigned sum overflow gives all ones; unsigned borrow gives 0; signed positive overflow gives max positive; signed negative overflow gives min negative.
REQ-027: OF_D is asserted on overflow regardless of SAT.
REQ-028: of_count increments by 1 on each output transfer with OF_D=1, and holds at all ones (no wrap).
REQ-029: clr_count loads of_count with 0; clear in the same cycle as an increment yields 0.

Reset
REQ-030: rst_n low asynchronously forces out_valid=0, the stage-1 valid bit=0, result=0, OF_D=0 and of_count=0; in_ready reads 1 while in reset.
REQ-031: Reset mid-operation discards all in-flight operand sets; there is no output transfer for them after reset release.
REQ-032: First input transfer is possible on the first rising edge after rst_n deasserts.

Verification
REQ-033: WIDTH=6, unsigned, SAT=0: mode=1, inA=45, inB=8 -> result=37, OF_D=0, out_valid two cycles after acceptance.
REQ-034: WIDTH=6, unsigned: mode=1, inA=3, inB=11 -> SAT=0 result=56, OF_D=1; SAT=1 result=0, OF_D=1; of_count increments to 1.
REQ-035: WIDTH=6, SIGNED=1: mode=0, inA=31, inB=1 -> SAT=0 result=6'b100000, OF_D=1; SAT=1 result=31, OF_D=1; mode=1, inA=-32, inB=1 -> SAT=1 result=-32, OF_D=1.
REQ-036: Back-to-back stream of 8 operand sets with out_ready toggling 1/0 -> all 8 results delivered in order, none duplicated or lost, in_ready low exactly while both stages are full and stalled.
REQ-037: 300 overflowing results with CNT_W=8 -> of_count sticks at 255; clr_count pulsed with a simultaneous overflow transfer -> of_count=0.
REQ-038: rst_n pulsed low with 2 operand sets in flight -> out_valid=0 immediately, of_count=0, no stale result after release.
